obs_align_checker: RTL

Relational observation checker for the self-composed (Left/Right) core harness. Captures the memory-port request stream of each copy, buffers it per copy to absorb stuttering skew, and compares the two streams entry by entry. Flags a sticky violation on the first divergence, skew overrun or buffer overflow. Sits beside the two core instances and drives the harness's verification-condition logic.

---
 rtl/obs_align_pkg.sv | 35 +++
 rtl/obs_fifo.sv | 53 +++++
 rtl/obs_align_checker.sv | 169 ++++++++++++++++
 3 files changed

// File: rtl/obs_align_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obs_align_pkg: shared types and entry sizing for the observation checker.
// Rev 1.0
// ---------------------------------------------------------------------------
package obs_align_pkg;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_MISMATCH = 2'd1,
    CAUSE_SKEW     = 2'd2,
    CAUSE_OVERFLOW = 2'd3
  } viol_cause_t;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_FAIL = 2'd2
  } chk_state_t;

  // Per-channel slice: {valid, addr, fcn, typ[2:0]} plus write data when observed.
  function automatic int chanWidth(input int aw, input int dw);
`ifdef OBS_DATA_EN
    return aw + 5 + dw;
`else
    return aw + 5 + 0 * dw;
`endif
  endfunction

  function automatic int entryWidth(input int nch, input int aw, input int dw);
    return nch * chanWidth(aw, dw);
  endfunction

endpackage
`default_nettype wire

// File: rtl/obs_fifo.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obs_fifo: single-clock FIFO with extra pointer bit for full/empty split.
// Rev 1.0
// ---------------------------------------------------------------------------
module obs_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clock,
  input  logic                     reset,
  input  logic                     push,
  input  logic                     pop,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int c_ptrW = $clog2(DEPTH) + 1;

  logic [c_ptrW-1:0] r_wrPtr;
  logic [c_ptrW-1:0] r_rdPtr;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic              w_doPush;
  logic              w_doPop;

  assign empty    = (r_wrPtr == r_rdPtr);
  assign full     = (r_wrPtr[c_ptrW-1] != r_rdPtr[c_ptrW-1]) &&
                    (r_wrPtr[c_ptrW-2:0] == r_rdPtr[c_ptrW-2:0]);
  assign level    = r_wrPtr - r_rdPtr;
  assign w_doPop  = pop && !empty;
  assign w_doPush = push && (!full || w_doPop);
  assign rdata    = r_mem[r_rdPtr[c_ptrW-2:0]];

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + c_ptrW'(1);
      if (w_doPop)  r_rdPtr <= r_rdPtr + c_ptrW'(1);
    end
  end

  // Storage needs no reset: the pointers alone define which words are live.
  always_ff @(posedge clock) begin
    if (w_doPush) r_mem[r_wrPtr[c_ptrW-2:0]] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/obs_align_checker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// obs_align_checker: buffers Left/Right request streams and compares them.
// OBS_DATA_EN adds write data to the compared observation. Rev 1.0
// ---------------------------------------------------------------------------
module obs_align_checker
  import obs_align_pkg::*;
#(
  parameter int NCH      = 3,
  parameter int AW       = 32,
  parameter int DW       = 32,
  parameter int DEPTH    = 4,
  parameter int MAX_SKEW = 8
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   stall_l,
  input  logic                   stall_r,
  input  logic [NCH-1:0]         req_valid_l,
  input  logic [NCH-1:0]         req_valid_r,
  input  logic [NCH*AW-1:0]      req_addr_l,
  input  logic [NCH*AW-1:0]      req_addr_r,
  input  logic [NCH-1:0]         req_fcn_l,
  input  logic [NCH-1:0]         req_fcn_r,
  input  logic [NCH*3-1:0]       req_typ_l,
  input  logic [NCH*3-1:0]       req_typ_r,
  input  logic [NCH*DW-1:0]      req_data_l,
  input  logic [NCH*DW-1:0]      req_data_r,
  output logic                   violation,
  output logic [1:0]             viol_cause,
  output logic [$clog2(NCH):0]   viol_chan,
  output logic [15:0]            match_count,
  output logic [$clog2(DEPTH):0] level_l,
  output logic [$clog2(DEPTH):0] level_r
);

  localparam int c_chanW  = chanWidth(AW, DW);
  localparam int c_entryW = entryWidth(NCH, AW, DW);
  localparam int c_selW   = $clog2(NCH) + 1;
  localparam int c_lvlW   = $clog2(DEPTH) + 1;
  localparam int c_skewW  = $clog2(MAX_SKEW + 1);

  chk_state_t          r_state;
  chk_state_t          w_nextState;
  viol_cause_t         r_cause;
  viol_cause_t         w_cause;
  logic                r_violation;
  logic [c_selW-1:0]   r_chan;
  logic [c_selW-1:0]   w_diffChan;
  logic [15:0]         r_matchCount;
  logic [c_skewW-1:0]  r_skew;
  logic [c_entryW-1:0] w_obsL, w_obsR, w_headL, w_headR;
  logic                w_fullL, w_fullR, w_emptyL, w_emptyR;
  logic                w_reqL, w_reqR, w_pushL, w_pushR, w_pop;
  logic                w_cmp, w_mismatch, w_overflow, w_oneSided, w_skewHit;

  for (genvar c = 0; c < NCH; c++) begin : g_obs
`ifdef OBS_DATA_EN
    assign w_obsL[c*c_chanW +: c_chanW] = req_valid_l[c]
      ? {1'b1, req_addr_l[c*AW +: AW], req_fcn_l[c], req_typ_l[c*3 +: 3],
         (req_fcn_l[c] ? req_data_l[c*DW +: DW] : {DW{1'b0}})}
      : '0;
    assign w_obsR[c*c_chanW +: c_chanW] = req_valid_r[c]
      ? {1'b1, req_addr_r[c*AW +: AW], req_fcn_r[c], req_typ_r[c*3 +: 3],
         (req_fcn_r[c] ? req_data_r[c*DW +: DW] : {DW{1'b0}})}
      : '0;
`else
    assign w_obsL[c*c_chanW +: c_chanW] = req_valid_l[c]
      ? {1'b1, req_addr_l[c*AW +: AW], req_fcn_l[c], req_typ_l[c*3 +: 3]} : '0;
    assign w_obsR[c*c_chanW +: c_chanW] = req_valid_r[c]
      ? {1'b1, req_addr_r[c*AW +: AW], req_fcn_r[c], req_typ_r[c*3 +: 3]} : '0;
`endif
  end

`ifndef OBS_DATA_EN
  logic w_unusedData;
  assign w_unusedData = ^{req_data_l, req_data_r};
`endif

  obs_fifo #(.WIDTH(c_entryW), .DEPTH(DEPTH)) u_fifoL (
    .clock(clock), .reset(reset), .push(w_pushL), .pop(w_pop), .wdata(w_obsL),
    .rdata(w_headL), .full(w_fullL), .empty(w_emptyL), .level(level_l)
  );

  obs_fifo #(.WIDTH(c_entryW), .DEPTH(DEPTH)) u_fifoR (
    .clock(clock), .reset(reset), .push(w_pushR), .pop(w_pop), .wdata(w_obsR),
    .rdata(w_headR), .full(w_fullR), .empty(w_emptyR), .level(level_r)
  );

  assign w_reqL     = (|req_valid_l) && !stall_l;
  assign w_reqR     = (|req_valid_r) && !stall_r;
  assign w_cmp      = !w_emptyL && !w_emptyR;
  assign w_mismatch = w_cmp && (w_headL != w_headR);
  assign w_overflow = !w_cmp && ((w_reqL && w_fullL) || (w_reqR && w_fullR));
  assign w_oneSided = w_emptyL ^ w_emptyR;
  assign w_skewHit  = w_oneSided && (r_skew == c_skewW'(MAX_SKEW - 1));

  always_comb begin
    w_diffChan = '1;
    for (int c = NCH - 1; c >= 0; c--) begin
      if (w_headL[c*c_chanW +: c_chanW] != w_headR[c*c_chanW +: c_chanW])
        w_diffChan = c_selW'(c);
    end
  end

  always_comb begin
    w_cause = CAUSE_NONE;
    if (w_overflow)      w_cause = CAUSE_OVERFLOW;
    else if (w_mismatch) w_cause = CAUSE_MISMATCH;
    else if (w_skewHit)  w_cause = CAUSE_SKEW;
  end

  // The violating cycle itself moves nothing, so the offending heads stay visible.
  always_comb begin
    w_nextState = r_state;
    w_pushL     = 1'b0;
    w_pushR     = 1'b0;
    w_pop       = 1'b0;
    case (r_state)
      ST_IDLE, ST_RUN: begin
        if (w_cause != CAUSE_NONE) begin
          w_nextState = ST_FAIL;
        end else begin
          w_pushL = w_reqL;
          w_pushR = w_reqR;
          w_pop   = w_cmp;
          if (((level_l + c_lvlW'(w_pushL) - c_lvlW'(w_pop)) == '0) &&
              ((level_r + c_lvlW'(w_pushR) - c_lvlW'(w_pop)) == '0))
            w_nextState = ST_IDLE;
          else
            w_nextState = ST_RUN;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) r_state <= ST_IDLE;
    else        r_state <= w_nextState;
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_violation  <= 1'b0;
      r_cause      <= CAUSE_NONE;
      r_chan       <= '0;
      r_matchCount <= '0;
      r_skew       <= '0;
    end else if (r_state != ST_FAIL) begin
      if (w_cause != CAUSE_NONE) begin
        r_violation <= 1'b1;
        r_cause     <= w_cause;
        r_chan      <= (w_cause == CAUSE_MISMATCH) ? w_diffChan : '1;
      end else begin
        r_skew <= w_oneSided ? r_skew + c_skewW'(1) : '0;
        if (w_pop && (r_matchCount != 16'hFFFF))
          r_matchCount <= r_matchCount + 16'd1;
      end
    end
  end

  assign violation   = r_violation;
  assign viol_cause  = r_cause;
  assign viol_chan   = r_chan;
  assign match_count = r_matchCount;

endmodule
`default_nettype wire
